// File: rtl/cpu_pkg.sv
// Shared CPU constants: address/counter widths, reset PC and PC-stage state encoding.
package cpu_pkg;

  localparam int unsigned PC_WIDTH  = 8;
  localparam int unsigned CNT_WIDTH = 8;
  localparam logic [PC_WIDTH-1:0] RESET_PC = 8'h00;

  // PC-stage run state; single bit so the registered state is the Halted flag itself.
  typedef enum logic {
    STATE_RUN    = 1'b0,
    STATE_HALTED = 1'b1
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: synchronous clear wins, otherwise step unless already saturated.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter, branch resolution and RUN/HALTED control for the 8-bit CPU.
module pc_branch_unit #(
  parameter int unsigned           PC_WIDTH  = cpu_pkg::PC_WIDTH,
  parameter logic [PC_WIDTH-1:0]   RESET_PC  = cpu_pkg::RESET_PC,
  parameter int unsigned           CNT_WIDTH = cpu_pkg::CNT_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 Zero,
  input  logic                 Branch,
  input  logic                 Jump,
  input  logic                 Halt,
  input  logic                 Stall,
  input  logic                 Start,
  input  logic [PC_WIDTH-1:0]  Offset,
  input  logic [PC_WIDTH-1:0]  JumpTarget,
  output logic [PC_WIDTH-1:0]  PC,
  output logic [PC_WIDTH-1:0]  PCPlus1,
  output logic                 Taken,
  output logic                 Halted,
  output logic [CNT_WIDTH-1:0] InstrCount,
  output logic [CNT_WIDTH-1:0] BranchCount
);

  import cpu_pkg::state_e;
  import cpu_pkg::STATE_RUN;
  import cpu_pkg::STATE_HALTED;

  state_e              state_q;
  state_e              state_d;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_d;
  logic [PC_WIDTH-1:0] branch_target;
  logic                retire;
  logic                instr_inc;
  logic                branch_inc;

  // Sequential and branch addresses; both wrap modulo 2^PC_WIDTH.
  assign PCPlus1       = pc_q + PC_WIDTH'(1);
  assign branch_target = PCPlus1 + Offset;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= STATE_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a non-stalled halt parks the stage, Start resumes it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      STATE_RUN: begin
        if (!Stall && Halt) begin
          state_d = STATE_HALTED;
        end
      end
      STATE_HALTED: begin
        if (Start) begin
          state_d = STATE_RUN;
        end
      end
      default: state_d = STATE_RUN;
    endcase
  end

  // Outputs decoded from state: retire/redirect qualifiers and counter strobes.
  always_comb begin
    retire     = 1'b0;
    Taken      = 1'b0;
    instr_inc  = 1'b0;
    branch_inc = 1'b0;
    if (state_q == STATE_RUN) begin
      retire     = !Stall;
      Taken      = !Stall && !Halt && (Jump || (Branch && Zero));
      instr_inc  = !Stall;
      branch_inc = !Stall && !Halt && !Jump && Branch && Zero;
    end
  end

  // Next PC, first match wins: halt holds, jump, taken branch, then fall-through.
  always_comb begin
    pc_d = pc_q;
    if (retire) begin
      if (Halt) begin
        pc_d = pc_q;
      end else if (Jump) begin
        pc_d = JumpTarget;
      end else if (Branch && Zero) begin
        pc_d = branch_target;
      end else begin
        pc_d = PCPlus1;
      end
    end else if ((state_q == STATE_HALTED) && Start) begin
      // Resume past the halt instruction.
      pc_d = PCPlus1;
    end
  end

  // PC register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_instr_cnt (
    .clock (clock),
    .reset (reset),
    .clear (1'b0),
    .inc   (instr_inc),
    .count (InstrCount)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_branch_cnt (
    .clock (clock),
    .reset (reset),
    .clear (1'b0),
    .inc   (branch_inc),
    .count (BranchCount)
  );

  assign PC     = pc_q;
  assign Halted = (state_q == STATE_HALTED);

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit with an expected-state scoreboard.
module tb_pc_branch_unit;

  logic       clock = 1'b0;
  logic       reset;
  logic       Zero, Branch, Jump, Halt, Stall, Start;
  logic [7:0] Offset, JumpTarget;
  logic [7:0] PC, PCPlus1;
  logic       Taken, Halted;
  logic [7:0] InstrCount, BranchCount;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      tag;
    logic [7:0] pc;
    logic       halted;
    logic [7:0] ic;
    logic [7:0] bc;
  } exp_t;

  exp_t sb[$];

  pc_branch_unit dut (
    .clock       (clock),
    .reset       (reset),
    .Zero        (Zero),
    .Branch      (Branch),
    .Jump        (Jump),
    .Halt        (Halt),
    .Stall       (Stall),
    .Start       (Start),
    .Offset      (Offset),
    .JumpTarget  (JumpTarget),
    .PC          (PC),
    .PCPlus1     (PCPlus1),
    .Taken       (Taken),
    .Halted      (Halted),
    .InstrCount  (InstrCount),
    .BranchCount (BranchCount)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic br, input logic zr, input logic jp, input logic ht,
                       input logic st, input logic sr, input logic [7:0] off,
                       input logic [7:0] tgt);
    Branch = br; Zero = zr; Jump = jp; Halt = ht;
    Stall = st; Start = sr; Offset = off; JumpTarget = tgt;
  endtask

  task automatic expect_next(input string tag, input logic [7:0] pc, input logic halted,
                             input logic [7:0] ic, input logic [7:0] bc);
    exp_t e;
    e.tag = tag; e.pc = pc; e.halted = halted; e.ic = ic; e.bc = bc;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".pc"}, PC, e.pc);
      chk({e.tag, ".halted"}, 8'(Halted), 8'(e.halted));
      chk({e.tag, ".ic"}, InstrCount, e.ic);
      chk({e.tag, ".bc"}, BranchCount, e.bc);
    end
  endtask

  task automatic chk_taken(input string tag, input logic exp);
    #1;
    chk({tag, ".taken"}, 8'(Taken), 8'(exp));
  endtask

  initial begin
    logic [7:0] exp_pc;
    logic [7:0] exp_ic;
    logic [7:0] exp_bc;

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    repeat (2) @(posedge clock);
    #1;
    chk("rst.pc", PC, 8'h00);
    chk("rst.halted", 8'(Halted), 8'h00);
    chk("rst.ic", InstrCount, 8'h00);
    chk("rst.bc", BranchCount, 8'h00);
    @(negedge clock) reset = 1'b0;

    // Build up PC=0x37 with nonzero counters.
    drive(0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    expect_next("nop0", 8'h01, 1'b0, 8'd1, 8'd0);
    tick();
    drive(1, 1, 0, 0, 0, 0, 8'h35, 8'h00);
    chk_taken("br37", 1'b1);
    expect_next("br37", 8'h37, 1'b0, 8'd2, 8'd1);
    tick();

    // Asynchronous reset mid-cycle, checked before any clock edge.
    #2 reset = 1'b1;
    #1;
    chk("arst.pc", PC, 8'h00);
    chk("arst.halted", 8'(Halted), 8'h00);
    chk("arst.ic", InstrCount, 8'h00);
    chk("arst.bc", BranchCount, 8'h00);
    drive(0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    @(negedge clock) reset = 1'b0;

    // Sequential fetch across the wrap point.
    drive(0, 0, 1, 0, 0, 0, 8'h00, 8'hFE);
    chk_taken("jmpFE", 1'b1);
    expect_next("jmpFE", 8'hFE, 1'b0, 8'd1, 8'd0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    chk("pcplus1FE", PCPlus1, 8'hFF);
    expect_next("seq1", 8'hFF, 1'b0, 8'd2, 8'd0);
    tick();
    chk("pcplus1FF", PCPlus1, 8'h00);
    expect_next("seq2", 8'h00, 1'b0, 8'd3, 8'd0);
    tick();
    expect_next("seq3", 8'h01, 1'b0, 8'd4, 8'd0);
    tick();

    // Backward branch taken and not taken.
    drive(0, 0, 1, 0, 0, 0, 8'h00, 8'h10);
    expect_next("jmp10a", 8'h10, 1'b0, 8'd5, 8'd0);
    tick();
    drive(1, 1, 0, 0, 0, 0, 8'hFC, 8'h00);
    chk_taken("brtk", 1'b1);
    expect_next("brtk", 8'h0D, 1'b0, 8'd6, 8'd1);
    tick();
    drive(0, 0, 1, 0, 0, 0, 8'h00, 8'h10);
    expect_next("jmp10b", 8'h10, 1'b0, 8'd7, 8'd1);
    tick();
    drive(1, 0, 0, 0, 0, 0, 8'hFC, 8'h00);
    chk_taken("brnt", 1'b0);
    expect_next("brnt", 8'h11, 1'b0, 8'd8, 8'd1);
    tick();

    // Jump beats taken branch; stall freezes everything.
    drive(1, 1, 1, 0, 0, 0, 8'hFC, 8'h80);
    chk_taken("jmpbr", 1'b1);
    expect_next("jmpbr", 8'h80, 1'b0, 8'd9, 8'd1);
    tick();
    drive(1, 1, 1, 0, 1, 0, 8'hFC, 8'h80);
    chk_taken("stall", 1'b0);
    expect_next("stall", 8'h80, 1'b0, 8'd9, 8'd1);
    tick();

    // Start while running is a plain fetch.
    drive(0, 0, 0, 0, 0, 1, 8'h00, 8'h00);
    expect_next("startrun", 8'h81, 1'b0, 8'd10, 8'd1);
    tick();

    // Halt wins over jump/branch, then stays parked.
    drive(0, 0, 1, 0, 0, 0, 8'h00, 8'h20);
    expect_next("jmp20", 8'h20, 1'b0, 8'd11, 8'd1);
    tick();
    drive(1, 1, 1, 1, 0, 0, 8'h04, 8'h80);
    chk_taken("halt", 1'b0);
    expect_next("halt", 8'h20, 1'b1, 8'd12, 8'd1);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 1, 0, 0, 0, 8'h04, 8'h80);
      chk_taken("halted", 1'b0);
      expect_next("halted", 8'h20, 1'b1, 8'd12, 8'd1);
      tick();
    end
    drive(0, 0, 0, 0, 0, 1, 8'h00, 8'h00);
    expect_next("resume", 8'h21, 1'b0, 8'd12, 8'd1);
    tick();

    // Reset while halted returns to RUN.
    drive(0, 0, 0, 1, 0, 0, 8'h00, 8'h00);
    expect_next("halt2", 8'h21, 1'b1, 8'd13, 8'd1);
    tick();
    #2 reset = 1'b1;
    #1;
    chk("hrst.halted", 8'(Halted), 8'h00);
    chk("hrst.pc", PC, 8'h00);
    chk("hrst.ic", InstrCount, 8'h00);
    drive(0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    @(negedge clock) reset = 1'b0;

    // Instruction counter saturation.
    exp_pc = 8'h00;
    exp_ic = 8'h00;
    for (int i = 0; i < 300; i++) begin
      exp_pc = exp_pc + 8'd1;
      if (exp_ic != 8'hFF) exp_ic = exp_ic + 8'd1;
      expect_next("icsat", exp_pc, 1'b0, exp_ic, 8'd0);
      tick();
    end
    chk("icsat.final", InstrCount, 8'hFF);

    // Branch counter saturation.
    exp_bc = 8'h00;
    drive(1, 1, 0, 0, 0, 0, 8'h00, 8'h00);
    for (int i = 0; i < 260; i++) begin
      exp_pc = exp_pc + 8'd1;
      if (exp_bc != 8'hFF) exp_bc = exp_bc + 8'd1;
      expect_next("bcsat", exp_pc, 1'b0, 8'hFF, exp_bc);
      tick();
    end
    chk("bcsat.final", BranchCount, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
